// File: rtl/vc_rr_scheduler.sv
// rtl/vc_rr_scheduler.sv - round-robin scheduler moving TLP words from four input VC FIFOs to four destination FIFOs
module vc_rr_scheduler #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [3:0]            pause,
  input  logic [3:0]            fifo_empty,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  output logic [3:0]            pop,
  output logic [3:0]            push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            grant_id,
  output logic                  idle,
  output logic                  stall,
  output logic [CNT_WIDTH-1:0]  grant_cnt0,
  output logic [CNT_WIDTH-1:0]  grant_cnt1,
  output logic [CNT_WIDTH-1:0]  grant_cnt2,
  output logic [CNT_WIDTH-1:0]  grant_cnt3
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [3:0]            push_q, push_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [1:0]            grant_id_q, grant_id_d;
  logic [CNT_WIDTH-1:0]  cnt_q [4];
  logic [CNT_WIDTH-1:0]  cnt_d [4];

  logic [DATA_WIDTH-1:0] head [4];
  logic [1:0]            dest [4];
  logic [3:0]            ready;
  logic [3:0]            elig;
  logic                  gnt_valid;
  logic [1:0]            gnt_idx;
  logic [1:0]            idx;
  logic                  has_data;
  logic                  any_ready;

  assign head[0] = data_in0;
  assign head[1] = data_in1;
  assign head[2] = data_in2;
  assign head[3] = data_in3;

  // Per-input destination decode and eligibility; ready ignores state so STALL can see unpaused work
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dest[i]  = head[i][DATA_WIDTH-1 -: 2];
      ready[i] = !fifo_empty[i] && !pause[dest[i]];
      elig[i]  = ready[i] && (state_q == ST_RUN);
    end
    has_data  = (fifo_empty != 4'hF);
    any_ready = |ready;
  end

  // Round-robin search starting at rr_ptr; first eligible input wins and is popped this cycle
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!gnt_valid && elig[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
    pop = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
  end

  // Run/stall/off control; disabling wins over every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable)                     state_d = ST_OFF;
        else if (has_data && !any_ready) state_d = ST_STALL;
      end
      ST_STALL: begin
        if (!enable)                     state_d = ST_OFF;
        else if (any_ready || !has_data) state_d = ST_RUN;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Next-cycle push of the granted word, pointer advance and saturating per-input counters
  always_comb begin
    push_d     = 4'b0000;
    data_out_d = data_out_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
    if (gnt_valid) begin
      push_d     = 4'b0001 << dest[gnt_idx];
      data_out_d = head[gnt_idx];
      grant_id_d = gnt_idx;
      rr_ptr_d   = gnt_idx + 2'd1;
      if (cnt_q[gnt_idx] != CNT_MAX) cnt_d[gnt_idx] = cnt_q[gnt_idx] + CNT_ONE;
    end
  end

  // State registers; reset drops any in-flight word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_OFF;
      rr_ptr_q   <= 2'd0;
      push_q     <= 4'b0000;
      data_out_q <= '0;
      grant_id_q <= 2'd0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      push_q     <= push_d;
      data_out_q <= data_out_d;
      grant_id_q <= grant_id_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign push       = push_q;
  assign data_out   = data_out_q;
  assign grant_id   = grant_id_q;
  assign stall      = (state_q == ST_STALL);
  assign idle       = (fifo_empty == 4'hF) && (push_q == 4'b0000);
  assign grant_cnt0 = cnt_q[0];
  assign grant_cnt1 = cnt_q[1];
  assign grant_cnt2 = cnt_q[2];
  assign grant_cnt3 = cnt_q[3];

endmodule

// File: tb/tb_vc_rr_scheduler.sv
// tb/tb_vc_rr_scheduler.sv - self-checking bench for vc_rr_scheduler
module tb_vc_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] pause;
  logic [3:0] empty;
  logic [9:0] d [4];
  logic [3:0] pop, push;
  logic [9:0] dout;
  logic [1:0] gid;
  logic       idle, stall;
  logic [7:0] gc0, gc1, gc2, gc3;

  int n_checks = 0;
  int n_fail   = 0;

  vc_rr_scheduler #(.DATA_WIDTH(10), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(rst_n), .enable(en), .pause(pause), .fifo_empty(empty),
    .data_in0(d[0]), .data_in1(d[1]), .data_in2(d[2]), .data_in3(d[3]),
    .pop(pop), .push(push), .data_out(dout), .grant_id(gid), .idle(idle), .stall(stall),
    .grant_cnt0(gc0), .grant_cnt1(gc1), .grant_cnt2(gc2), .grant_cnt3(gc3)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = off, 1 = run, 2 = stall
  int         m_state;
  int         m_rr;
  int         m_cnt [4];
  logic [3:0] m_push;
  logic [9:0] m_dout;
  int         m_gid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(int i);
    int dst;
    dst = int'(d[i] >> 8);
    return !empty[i] && !pause[dst];
  endfunction

  function automatic int m_grant();
    if (m_state != 1) return -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_rr + k) % 4;
      if (m_ready(i)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_rr = 0; m_push = 4'h0; m_dout = 10'h0; m_gid = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_update();
    int  g;
    bit  anyr;
    bit  hasd;
    g = m_grant();
    anyr = 0;
    for (int i = 0; i < 4; i++) if (m_ready(i)) anyr = 1;
    hasd = (empty != 4'hF);
    if (g >= 0) begin
      m_push = 4'h0;
      m_push[int'(d[g] >> 8)] = 1'b1;
      m_dout = d[g];
      m_gid  = g;
      m_rr   = (g + 1) % 4;
      if (m_cnt[g] < 255) m_cnt[g]++;
    end else begin
      m_push = 4'h0;
    end
    case (m_state)
      0: if (en) m_state = 1;
      1: if (!en) m_state = 0; else if (hasd && !anyr) m_state = 2;
      default: if (!en) m_state = 0; else if (anyr || !hasd) m_state = 1;
    endcase
  endtask

  // Wait for the falling edge and compare every output against the model
  task automatic sample();
    int         g;
    logic [3:0] ep;
    @(negedge clk);
    g  = m_grant();
    ep = 4'h0;
    if (g >= 0) ep[g] = 1'b1;
    chk("m_pop", pop, ep);
    chk("m_push", push, m_push);
    chk("m_data_out", dout, m_dout);
    chk("m_grant_id", gid, m_gid[1:0]);
    chk("m_idle", idle, (empty == 4'hF) && (m_push == 4'h0));
    chk("m_stall", stall, m_state == 2);
    chk("m_cnt0", gc0, m_cnt[0]);
    chk("m_cnt1", gc1, m_cnt[1]);
    chk("m_cnt2", gc2, m_cnt[2]);
    chk("m_cnt3", gc3, m_cnt[3]);
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; pause = 4'h0; empty = 4'hF;
    for (int i = 0; i < 4; i++) d[i] = 10'h0;
    advance();
    advance();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic [3:0] pause;
    logic [3:0] empty;
    logic [9:0] d0, d1, d2, d3;
    logic [3:0] pop;
    logic [3:0] push;
    logic [9:0] dout;
    logic       stall;
    logic       idle;
  } vec_t;

  vec_t tbl [14];

  localparam logic [9:0] A0 = 10'h301, A1 = 10'h202, A2 = 10'h103, A3 = 10'h004;
  localparam logic [9:0] B2 = 10'h122, B3 = 10'h133;

  initial begin
    bit found;

    tbl[0]  = '{1'b1, 4'h0, 4'hF, A0, A1, A2, A3, 4'h0, 4'h0, 10'h000, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 4'h0, 4'h0, A0, A1, A2, A3, 4'h1, 4'h0, 10'h000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'h0, 4'h1, A0, A1, A2, A3, 4'h2, 4'h8, A0,      1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'h0, 4'h3, A0, A1, A2, A3, 4'h4, 4'h4, A1,      1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'h0, 4'h7, A0, A1, A2, A3, 4'h8, 4'h2, A2,      1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'h0, 4'hF, A0, A1, A2, A3, 4'h0, 4'h1, A3,      1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'h0, 4'hF, A0, A1, A2, A3, 4'h0, 4'h0, A3,      1'b0, 1'b1};
    tbl[7]  = '{1'b1, 4'h2, 4'h3, B2, B2, B2, B3, 4'h0, 4'h0, A3,      1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'h2, 4'h3, B2, B2, B2, B3, 4'h0, 4'h0, A3,      1'b1, 1'b0};
    tbl[9]  = '{1'b1, 4'h0, 4'h3, B2, B2, B2, B3, 4'h0, 4'h0, A3,      1'b1, 1'b0};
    tbl[10] = '{1'b1, 4'h0, 4'h3, B2, B2, B2, B3, 4'h4, 4'h0, A3,      1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'h0, 4'h7, B2, B2, B2, B3, 4'h8, 4'h2, B2,      1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'h0, 4'hF, B2, B2, B2, B3, 4'h0, 4'h2, B3,      1'b0, 1'b0};
    tbl[13] = '{1'b1, 4'h0, 4'hF, B2, B2, B2, B3, 4'h0, 4'h0, B3,      1'b0, 1'b1};

    model_reset();
    do_reset();

    // Reset values, sampled while reset is still asserted
    rst_n = 1'b0;
    sample();
    chk("rst_pop", pop, 4'h0);
    chk("rst_push", push, 4'h0);
    chk("rst_data_out", dout, 10'h0);
    chk("rst_grant_id", gid, 2'd0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_cnt", {gc0, gc1, gc2, gc3}, 32'h0);
    advance();
    rst_n = 1'b1;

    // Table-driven ordered drain and pause/stall sequence
    for (int r = 0; r < 14; r++) begin
      en = tbl[r].en; pause = tbl[r].pause; empty = tbl[r].empty;
      d[0] = tbl[r].d0; d[1] = tbl[r].d1; d[2] = tbl[r].d2; d[3] = tbl[r].d3;
      sample();
      chk($sformatf("tbl%0d_pop", r), pop, tbl[r].pop);
      chk($sformatf("tbl%0d_push", r), push, tbl[r].push);
      chk($sformatf("tbl%0d_data_out", r), dout, tbl[r].dout);
      chk($sformatf("tbl%0d_stall", r), stall, tbl[r].stall);
      chk($sformatf("tbl%0d_idle", r), idle, tbl[r].idle);
      if (r == 6) chk("tbl_cnt_each_one", {gc0, gc1, gc2, gc3}, 32'h01010101);
      advance();
    end

    // Inputs 0 and 2 alternate; input 3 joins and must be served within 3 cycles
    do_reset();
    en = 1'b1;
    sample(); advance();
    empty = 4'b1010; d[0] = 10'h0AA; d[2] = 10'h0BB;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("alt_pop", pop, (k % 2 == 0) ? 4'h1 : 4'h4);
      advance();
    end
    empty = 4'b0010; d[3] = 10'h3CC;
    found = 0;
    for (int k = 0; k < 3 && !found; k++) begin
      sample();
      if (pop[3]) found = 1;
      advance();
    end
    chk("late_input3_served", found, 1'b1);

    // Reset asserted mid-transfer: everything clears at once, in-flight word dropped
    sample();
    chk("pre_reset_pop_active", pop != 4'h0, 1'b1);
    rst_n = 1'b0; empty = 4'hF;
    #1;
    chk("midrst_push", push, 4'h0);
    chk("midrst_pop", pop, 4'h0);
    chk("midrst_cnt", {gc0, gc1, gc2, gc3}, 32'h0);
    chk("midrst_grant_id", gid, 2'd0);
    chk("midrst_idle", idle, 1'b1);
    advance();
    sample();
    chk("midrst_push_hold", push, 4'h0);
    advance();
    rst_n = 1'b1; en = 1'b1; empty = 4'h0;
    for (int i = 0; i < 4; i++) d[i] = 10'h011 + 10'(i);
    sample(); advance();
    sample();
    chk("restart_at_input0", pop, 4'h1);
    advance();

    // Pause rises while a word to that destination is in flight
    do_reset();
    en = 1'b1;
    sample(); advance();
    empty = 4'b1101; d[1] = 10'h255;
    sample();
    chk("inflight_grant", pop, 4'h2);
    advance();
    pause = 4'b0100;
    sample();
    chk("inflight_no_regrant", pop, 4'h0);
    chk("inflight_push", push, 4'h4);
    advance();
    sample();
    chk("inflight_after_push", push, 4'h0);
    advance();
    sample();
    chk("inflight_stall", stall, 1'b1);
    advance();

    // Counter saturation on input 0
    do_reset();
    en = 1'b1; empty = 4'b1110; d[0] = 10'h012;
    for (int k = 0; k < 300; k++) begin
      sample(); advance();
    end
    sample();
    chk("cnt0_saturated", gc0, 8'd255);
    advance();

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      en    = ($urandom_range(0, 15) != 0);
      pause = 4'($urandom) & 4'($urandom);
      empty = 4'($urandom);
      for (int i = 0; i < 4; i++) d[i] = 10'($urandom);
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
